// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core MA stage (port 0) and the debug/loader port (port 1).
// One access in flight: gnt 1 cycle after req is sampled, rvalid RD_LAT+2 cycles after; a losing req waits in place.
module dmem_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [3:0]        p0_wstrb,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [3:0]        p1_wstrb,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_e              state_q, state_d;
    logic                winner_q, winner_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                we_q, we_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                sel;

    // rr_ptr only breaks ties; a lone requester always wins.
    assign sel = (p0_req && p1_req) ? ((PRIO_MODE == 1) ? 1'b1 : rr_ptr_q) : p1_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            rr_ptr_q <= 1'b0;
            we_q     <= 1'b0;
            wstrb_q  <= 4'b0;
            addr_q   <= '0;
            wdata_q  <= 32'b0;
            rdata_q  <= 32'b0;
            cnt_q    <= 3'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        rr_ptr_d  = rr_ptr_q;
        we_d      = we_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wstrb = 4'b0;
        mem_addr  = '0;
        mem_wdata = 32'b0;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    winner_d = sel;
                    we_d     = sel ? p1_we    : p0_we;
                    wstrb_d  = sel ? p1_wstrb : p0_wstrb;
                    addr_d   = sel ? p1_addr  : p0_addr;
                    wdata_d  = sel ? p1_wdata : p0_wdata;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_wstrb = we_q ? wstrb_q : 4'b0;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                p0_gnt    = ~winner_q;
                p1_gnt    = winner_q;
                rr_ptr_d  = ~winner_q;
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                // cnt reaches zero on the cycle mem_rdata becomes valid
                if (cnt_q == 3'd0) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                p0_rvalid = ~winner_q;
                p1_rvalid = winner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Drives three arbiters (round-robin RD_LAT=1, fixed-priority RD_LAT=1, round-robin RD_LAT=3) with shared stimulus style
// and checks every cycle against a transaction-level model built from the latency and selection rules.
module tb_dmem_arbiter;
    localparam int NK = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  req   [NK];
    logic [1:0]  we    [NK];
    logic [3:0]  strb  [NK][2];
    logic [10:0] addr  [NK][2];
    logic [31:0] wd    [NK][2];
    logic        gnt0  [NK];
    logic        gnt1  [NK];
    logic        rv0   [NK];
    logic        rv1   [NK];
    logic        men   [NK];
    logic        mwe   [NK];
    logic        bsy   [NK];
    logic [3:0]  mstrb [NK];
    logic [10:0] maddr [NK];
    logic [31:0] mwd   [NK];
    logic [31:0] mrd   [NK];
    logic [31:0] rdat  [NK];
    logic [31:0] pipe  [NK][8];
    logic [31:0] bmem  [NK][2048];
    logic [31:0] mmem  [NK][2048];

    int checks = 0;
    int failures = 0;
    bit hold_mode = 1'b0;
    bit rnd_mode = 1'b0;

    function automatic int lat(int k);
        return (k == 2) ? 3 : 1;
    endfunction
    function automatic bit prio(int k);
        return (k == 1);
    endfunction
    function automatic logic [31:0] seed_word(int k, int a);
        return (32'h9E3779B9 * 32'(a + 1)) ^ 32'(k);
    endfunction

    generate
        for (genvar k = 0; k < NK; k++) begin : g_dut
            dmem_arbiter #(.ADDR_W(11), .RD_LAT((k == 2) ? 3 : 1), .PRIO_MODE((k == 1) ? 1 : 0)) u_dut (
                .clk(clk), .rst(rst),
                .p0_req(req[k][0]), .p0_we(we[k][0]), .p0_wstrb(strb[k][0]), .p0_addr(addr[k][0]),
                .p0_wdata(wd[k][0]), .p0_gnt(gnt0[k]), .p0_rvalid(rv0[k]),
                .p1_req(req[k][1]), .p1_we(we[k][1]), .p1_wstrb(strb[k][1]), .p1_addr(addr[k][1]),
                .p1_wdata(wd[k][1]), .p1_gnt(gnt1[k]), .p1_rvalid(rv1[k]),
                .rdata(rdat[k]), .mem_en(men[k]), .mem_we(mwe[k]), .mem_wstrb(mstrb[k]),
                .mem_addr(maddr[k]), .mem_wdata(mwd[k]), .mem_rdata(mrd[k]), .busy(bsy[k]));
            assign mrd[k] = pipe[k][((k == 2) ? 3 : 1) - 1];
        end
    endgenerate

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
        end
    endtask

    // Memory with a RD_LAT-deep output pipe; acts on the command visible just before each rising edge.
    initial begin
        logic c_en [NK];
        logic c_we [NK];
        logic [3:0] c_st [NK];
        logic [10:0] c_ad [NK];
        logic [31:0] c_wd [NK];
        for (int k = 0; k < NK; k++) begin
            for (int a = 0; a < 2048; a++) bmem[k][a] = seed_word(k, a);
            bmem[k][11'h020] = 32'h12345678;
            for (int i = 0; i < 8; i++) pipe[k][i] <= 32'h0;
        end
        forever begin
            @(negedge clk); #1;
            for (int k = 0; k < NK; k++) begin
                c_en[k] = men[k]; c_we[k] = mwe[k]; c_st[k] = mstrb[k]; c_ad[k] = maddr[k]; c_wd[k] = mwd[k];
            end
            @(posedge clk);
            for (int k = 0; k < NK; k++) begin
                if (c_en[k] && rst) begin
                    if (c_we[k])
                        for (int b = 0; b < 4; b++)
                            if (c_st[k][b]) bmem[k][c_ad[k]][8*b +: 8] = c_wd[k][8*b +: 8];
                    pipe[k][0] <= bmem[k][c_ad[k]];
                end
                for (int i = 7; i >= 1; i--) pipe[k][i] <= pipe[k][i-1];
            end
        end
    end

    // Reference model: edge number e, one transaction record per arbiter, memory image.
    int          e;
    bit          tv    [NK];
    bit          tport [NK];
    bit          twe   [NK];
    logic [3:0]  tstrb [NK];
    logic [10:0] taddr [NK];
    logic [31:0] twd   [NK];
    logic [31:0] trd   [NK];
    logic [31:0] xrd   [NK];
    int          iss   [NK];
    int          free_e[NK];
    bit          rrp   [NK];

    initial begin
        for (int k = 0; k < NK; k++) begin
            for (int a = 0; a < 2048; a++) mmem[k][a] = seed_word(k, a);
            mmem[k][11'h020] = 32'h12345678;
        end
        e = 0;
        for (int k = 0; k < NK; k++) begin
            tv[k] = 0; iss[k] = -100; free_e[k] = 0; rrp[k] = 0; xrd[k] = 32'h0;
        end
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                e = 0;
                for (int k = 0; k < NK; k++) begin
                    tv[k] = 0; iss[k] = -100; free_e[k] = 0; rrp[k] = 0; xrd[k] = 32'h0;
                end
            end else begin
                e++;
                for (int k = 0; k < NK; k++) begin
                    bit w;
                    if (tv[k] && twe[k] && e == iss[k] + 1)
                        for (int b = 0; b < 4; b++)
                            if (tstrb[k][b]) mmem[k][taddr[k]][8*b +: 8] = twd[k][8*b +: 8];
                    if (tv[k] && !twe[k] && e == iss[k] + lat(k) + 1) xrd[k] = trd[k];
                    if (e >= free_e[k] && (req[k][0] || req[k][1])) begin
                        if (req[k][0] && req[k][1]) w = prio(k) ? 1'b1 : rrp[k];
                        else w = req[k][1];
                        tv[k] = 1; tport[k] = w; iss[k] = e;
                        twe[k] = we[k][w]; tstrb[k] = strb[k][w]; taddr[k] = addr[k][w]; twd[k] = wd[k][w];
                        trd[k] = mmem[k][addr[k][w]];
                        free_e[k] = we[k][w] ? e + 2 : e + lat(k) + 3;
                        rrp[k] = ~w;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk); #1;
            for (int k = 0; k < NK; k++) begin
                bit isn;
                bit rvn;
                isn = tv[k] && (e == iss[k]);
                rvn = tv[k] && !twe[k] && (e == iss[k] + lat(k) + 1);
                chk("gnt0", k, 32'(gnt0[k]), 32'(isn && !tport[k]));
                chk("gnt1", k, 32'(gnt1[k]), 32'(isn && tport[k]));
                chk("mem_en", k, 32'(men[k]), 32'(isn));
                chk("rvalid0", k, 32'(rv0[k]), 32'(rvn && !tport[k]));
                chk("rvalid1", k, 32'(rv1[k]), 32'(rvn && tport[k]));
                chk("busy", k, 32'(bsy[k]), 32'(e + 1 < free_e[k]));
                chk("rdata", k, rdat[k], xrd[k]);
                if (isn) begin
                    chk("mem_we", k, 32'(mwe[k]), 32'(twe[k]));
                    chk("mem_wstrb", k, 32'(mstrb[k]), twe[k] ? 32'(tstrb[k]) : 32'h0);
                    chk("mem_addr", k, 32'(maddr[k]), 32'(taddr[k]));
                    chk("mem_wdata", k, mwd[k], twd[k]);
                end
            end
        end
    end

    task automatic new_fields(int k, int p);
        we[k][p]   = 1'($urandom_range(1, 0));
        strb[k][p] = 4'($urandom_range(15, 1));
        addr[k][p] = 11'($urandom_range(63, 0));
        wd[k][p]   = $urandom;
    endtask

    task automatic tick();
        @(negedge clk); #2;
        for (int k = 0; k < NK; k++) begin
            for (int p = 0; p < 2; p++) begin
                logic g;
                g = p ? gnt1[k] : gnt0[k];
                if (req[k][p] && g && !hold_mode) begin
                    if (rnd_mode && $urandom_range(1, 0) != 0) new_fields(k, p);
                    else req[k][p] = 1'b0;
                end else if (!req[k][p] && rnd_mode && $urandom_range(3, 0) == 0) begin
                    req[k][p] = 1'b1;
                    new_fields(k, p);
                end
            end
        end
    endtask

    initial begin
        int qg[$];
        int c10, c11, n;
        rst = 1'b0;
        for (int k = 0; k < NK; k++) begin
            req[k] = 2'b11; we[k] = 2'b01;
            strb[k][0] = 4'hF; strb[k][1] = 4'hF;
            addr[k][0] = 11'h010; addr[k][1] = 11'h020;
            wd[k][0] = 32'hDEADBEEF; wd[k][1] = 32'hAAAA5555;
        end
        repeat (3) @(negedge clk);
        #2;
        for (int k = 0; k < NK; k++) begin
            chk("rst_busy", k, 32'(bsy[k]), 0);
            chk("rst_mem_en", k, 32'(men[k]), 0);
            chk("rst_gnt", k, 32'({gnt1[k], gnt0[k]}), 0);
            chk("rst_rdata", k, rdat[k], 0);
        end
        rst = 1'b1;

        tick(); // edge 1
        chk("w_gnt0", 0, 32'(gnt0[0]), 1);
        chk("w_gnt1", 0, 32'(gnt1[0]), 0);
        chk("w_mem_we", 0, 32'(mwe[0]), 1);
        chk("w_mem_addr", 0, 32'(maddr[0]), 32'h010);
        chk("w_mem_wdata", 0, mwd[0], 32'hDEADBEEF);
        chk("w_mem_wstrb", 0, 32'(mstrb[0]), 32'hF);
        chk("prio_gnt1", 1, 32'(gnt1[1]), 1);
        chk("prio_rd_wstrb", 1, 32'(mstrb[1]), 0);
        tick(); // edge 2
        chk("w_done_busy", 0, 32'(bsy[0]), 0);
        tick(); // edge 3
        chk("rd_gnt1", 0, 32'(gnt1[0]), 1);
        chk("rd_mem_we", 0, 32'(mwe[0]), 0);
        tick(); // edge 4: core request arrives while the slow port is in WAIT
        req[2][0] = 1'b1; we[2][0] = 1'b1; addr[2][0] = 11'h011; wd[2][0] = 32'h0BADF00D; strb[2][0] = 4'h3;
        tick(); // edge 5
        chk("rd_rvalid1", 0, 32'(rv1[0]), 1);
        chk("rd_rvalid0", 0, 32'(rv0[0]), 0);
        chk("rd_rdata", 0, rdat[0], 32'h12345678);
        tick(); // edge 6
        chk("lat3_rdata_pre", 2, rdat[2], 0);
        chk("lat3_rvalid_pre", 2, 32'(rv1[2]), 0);
        tick(); // edge 7
        chk("lat3_rvalid", 2, 32'(rv1[2]), 1);
        chk("lat3_rdata", 2, rdat[2], 32'h12345678);
        tick(); // edge 8
        chk("lat3_wait_gnt0", 2, 32'(gnt0[2]), 0);
        tick(); // edge 9
        chk("lat3_late_gnt0", 2, 32'(gnt0[2]), 1);
        repeat (8) tick();

        for (int k = 0; k < NK; k++) begin
            we[k] = 2'b11; addr[k][0] = 11'h030; addr[k][1] = 11'h031; req[k] = 2'b11;
        end
        hold_mode = 1'b1;
        c10 = 0; c11 = 0;
        repeat (20) begin
            tick();
            if (gnt0[0]) qg.push_back(0);
            if (gnt1[0]) qg.push_back(1);
            c10 += int'(gnt0[1]);
            c11 += int'(gnt1[1]);
        end
        chk("rr_count", 0, 32'(qg.size() >= 8), 1);
        for (int i = 0; i < qg.size(); i++) chk("rr_alternate", 0, 32'(qg[i]), 32'(i % 2));
        chk("prio_p0_never", 1, 32'(c10), 0);
        chk("prio_p1_count", 1, 32'(c11 >= 8), 1);
        hold_mode = 1'b0;
        for (int k = 0; k < NK; k++) req[k] = 2'b00;
        repeat (8) tick();

        req[2][1] = 1'b1; we[2][1] = 1'b0; addr[2][1] = 11'h020;
        n = 0;
        do begin tick(); n++; end while (!gnt1[2] && n < 10);
        chk("abort_gnt_seen", 2, 32'(gnt1[2]), 1);
        tick();
        chk("abort_busy_wait", 2, 32'(bsy[2]), 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 2, 32'(bsy[2]), 0);
        chk("abort_mem_en", 2, 32'(men[2]), 0);
        chk("abort_rdata", 2, rdat[2], 0);
        tick();
        tick();
        rst = 1'b1;
        req[2][0] = 1'b1; we[2][0] = 1'b0; addr[2][0] = 11'h020;
        n = 0;
        do begin tick(); n++; end while (!rv0[2] && n < 12);
        chk("after_abort_rvalid0", 2, 32'(rv0[2]), 1);
        chk("after_abort_rdata", 2, rdat[2], 32'h12345678);

        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(599, 0) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
        end
        rnd_mode = 1'b0;
        for (int k = 0; k < NK; k++) req[k] = 2'b00;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
